led_scan_decoder: RTL and testbench
===================================

# led_scan_decoder

Passive monitor for a multiplexed 8-digit, 7-segment display bus. Samples the scanned digit-enable and segment lines produced by the display controller and decodes each scanned digit back to a 4-bit code. Presents a complete 8-digit frame with a one-cycle valid strobe. Used for on-board loopback checking and for the display-path testbench; it never drives the display.

## Interface
- `SETTLE`, default 2: number of cycles the registered inputs must be unchanged before a digit is captured.
- `TIMEOUT`, default 64: cycles without any capture before a partial frame is discarded.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `led_en` input 8: digit enables, active-low. Bit 7 is the leftmost digit (slot 7).
- `led_ca`..`led_cg` input 1 each: segments a–g, active-low.
- `led_dp` input 1: decimal point, active-low.
- `digits` output 32: last complete frame. Slot k occupies bits [4k+3:4k].
- `frame_valid` output 1: one-cycle pulse when `digits` updates.
- `frame_err` output 1: error flag for the frame just presented. Valid while `frame_valid` is high and held until the next frame.
- `dp_mask` output 8: decimal-point state per slot, 1 = lit.

## Operation
- All inputs are registered twice (`in_q`, `in_qq`) as a 16-bit vector {led_en, dp, g..a}.
- Stability counter:
  - cleared when `in_q` != `in_qq`;
  - otherwise increments, saturating at SETTLE.
  - A capture event fires once per dwell, on the cycle the counter steps from SETTLE-1 to SETTLE.
- Capture classification on `in_q.led_en`:
  - Exactly one bit low: valid. Slot = index of the low bit.
  - 8'hFF: blanking interval. No capture, no error.
  - More than one bit low: no capture. Sets the pending-error flag.
- Segment decode, pattern {g,f,e,d,c,b,a}:

  | Pattern | Code |
  |---|---|
  | 1000000 | 0 |
  | 1111001 | 1 |
  | 0100100 | 2 |
  | 0110000 | 3 |
  | 0011001 | 4 |
  | 0010010 | 5 |
  | 0000010 | 6 |
  | 1111000 | 7 |
  | 0000000 | 8 |
  | 0011000 | 9 |
  | 1111111 | 4'hF (blank) |
  | any other | 4'hE, and sets pending-error |

- Each capture writes the pending slot register and sets bit k of an 8-bit captured mask. Recapturing an already-set slot overwrites it; this is not an error.
- FSM states:
  - COLLECT (mask partial). When the mask becomes 8'hFF, go to EMIT.
  - EMIT (one cycle):
    - `digits` <= pending slots; `dp_mask` <= pending dp;
    - `frame_err` <= pending-error; `frame_valid` <= 1;
    - clear the mask and pending-error;
    - return to COLLECT.
- Timeout counter:
  - clears on every capture; counts otherwise, saturating.
  - On reaching TIMEOUT with a nonzero mask: clear the mask and pending-error. No output change.
- Reset values: `digits` = 32'hFFFF_FFFF; `frame_valid` = 0; `frame_err` = 0; `dp_mask` = 8'h00; mask, counters, pending registers and input registers all zero/blank.

## Timing
- An input change that then holds produces its capture on the 4th rising edge after the change for SETTLE = 2 (SETTLE+2 in general). Minimum dwell per digit is SETTLE+2 cycles; a shorter dwell is never captured.
- `frame_valid` rises on the edge after the capture that completes the mask. `digits` changes on that same edge.
- A capture in the EMIT cycle is applied to the new, cleared mask. It is not lost.
- `rst` asserted mid-frame: all registers take reset values on that edge and the partial frame is discarded. With `rst` high, no capture or emit occurs.
- Timeout and capture in the same cycle: capture wins and the timeout counter clears.

## Configuration
- `LED_SCAN_DP_EN` defined: `led_dp` is registered and included in the stability vector; `dp_mask` reports the captured dp per slot.
- `LED_SCAN_DP_EN` undefined: `led_dp` is ignored (not part of the stability comparison) and `dp_mask` is held at 8'h00.

## Test plan
- Scan slots 7→0 showing 1,0,2,0,1,0,2,8, dwell 4 cycles each, 4 cycles of 8'hFF between frames → exactly one `frame_valid` per scan, `digits` = 32'h10201028, `frame_err` = 0.
- Same scan with a 3-cycle dwell → `frame_valid` never asserts; `digits` stays 32'hFFFF_FFFF.
- Slot 3 segments 7'b1010101, other slots as in the first test → `digits` = 32'h1020E028, `frame_err` = 1.
- `led_en` = 8'h00 for 6 cycles mid-scan, then the scan completes → `frame_err` = 1. The next clean scan gives `frame_err` = 0.
- Five digits, then `led_en` = 8'hFF for 70 cycles, then a full scan of 9,8,7,6,5,4,3,2 → one `frame_valid`, `digits` = 32'h98765432.
- `rst` for 1 cycle after four digits → outputs at reset values on the next edge; the following full scan emits normally. With `LED_SCAN_DP_EN`, dp low on slot 0 only → `dp_mask` = 8'h01.

Source files
------------

// File: rtl/led_scan_decoder.sv
// led_scan_decoder: passive monitor that decodes a scanned 8-digit 7-segment bus into whole frames.
// Optional LED_SCAN_DP_EN: register led_dp, include it in the stability check and report it in dp_mask.
module led_scan_decoder #(
    parameter int SETTLE = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_en,
    input  logic        led_ca,
    input  logic        led_cb,
    input  logic        led_cc,
    input  logic        led_cd,
    input  logic        led_ce,
    input  logic        led_cf,
    input  logic        led_cg,
    input  logic        led_dp,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  dp_mask
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [15:0] raw, in_q, in_qq;
    logic [SW-1:0] st_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0] mask, mask_n, en_l;
    logic [31:0] pend;
    logic [0:0] state;
    logic [2:0] slot;
    logic [3:0] code;
    logic pend_err, fire, one_hot, cap, cap_err, emit, timeout;

`ifdef LED_SCAN_DP_EN
    logic [7:0] pend_dp;
    assign raw = {led_en, led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
`else
    // dp is forced to its unlit level so it never disturbs the stability check
    assign raw = {led_en, led_dp | 1'b1, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
`endif

    // the bus must still hold on the capture edge, so a dwell shorter than SETTLE+2 is rejected
    assign fire = (in_q == in_qq) && (st_cnt == SW'(SETTLE - 1)) && (raw == in_q);
    assign en_l = ~in_q[15:8];
    assign one_hot = (en_l != 8'h00) && ((en_l & (en_l - 8'd1)) == 8'h00);
    assign cap = fire && one_hot;
    assign cap_err = fire && (one_hot ? (code == 4'hE) : (en_l != 8'h00));
    assign emit = (state == EMIT);
    assign timeout = !cap && (to_cnt == TW'(TIMEOUT)) && (mask != 8'h00);
    assign mask_n = ((emit || timeout) ? 8'h00 : mask) | (cap ? (8'h01 << slot) : 8'h00);

    always_comb begin
        slot = 3'd0;
        for (int i = 0; i < 8; i++) if (en_l[i]) slot = 3'(i);
    end

    always_comb begin
        case (in_q[6:0])
            7'b1000000: code = 4'h0;
            7'b1111001: code = 4'h1;
            7'b0100100: code = 4'h2;
            7'b0110000: code = 4'h3;
            7'b0011001: code = 4'h4;
            7'b0010010: code = 4'h5;
            7'b0000010: code = 4'h6;
            7'b1111000: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0011000: code = 4'h9;
            7'b1111111: code = 4'hF;
            default:    code = 4'hE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '1;
            in_qq <= '1;
            st_cnt <= '0;
            to_cnt <= '0;
            mask <= '0;
            pend <= '1;
            pend_err <= 1'b0;
            state <= COLLECT;
            digits <= '1;
            frame_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            in_q <= raw;
            in_qq <= in_q;
            st_cnt <= (in_q != in_qq) ? '0 : (st_cnt == SW'(SETTLE)) ? st_cnt : st_cnt + SW'(1);
            to_cnt <= cap ? '0 : (to_cnt == TW'(TIMEOUT)) ? to_cnt : to_cnt + TW'(1);
            mask <= mask_n;
            pend_err <= ((emit || timeout) ? 1'b0 : pend_err) | cap_err;
            state <= (mask_n == 8'hFF) ? EMIT : COLLECT;
            frame_valid <= emit;
            if (cap) pend[{slot, 2'b00} +: 4] <= code;
            if (emit) begin
                digits <= pend;
                frame_err <= pend_err;
            end
        end
    end

`ifdef LED_SCAN_DP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_dp <= '0;
            dp_mask <= '0;
        end else begin
            if (cap) pend_dp[slot] <= ~in_q[7];
            if (emit) dp_mask <= pend_dp;
        end
    end
`else
    assign dp_mask = 8'h00;
`endif
endmodule

// File: tb/tb_led_scan_decoder.sv
// tb_led_scan_decoder: table-driven scans plus hand sequences, frames checked through an expected-frame queue.
module tb_led_scan_decoder;
`ifdef LED_SCAN_DP_EN
    localparam bit DP = 1'b1;
`else
    localparam bit DP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] led_en = 8'hFF;
    logic led_ca = 1'b1, led_cb = 1'b1, led_cc = 1'b1, led_cd = 1'b1;
    logic led_ce = 1'b1, led_cf = 1'b1, led_cg = 1'b1, led_dp = 1'b1;
    logic [31:0] digits;
    logic frame_valid, frame_err;
    logic [7:0] dp_mask;

    always #5 clk = ~clk;

    led_scan_decoder dut (
        .clk(clk), .rst(rst), .led_en(led_en),
        .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
        .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp),
        .digits(digits), .frame_valid(frame_valid), .frame_err(frame_err), .dp_mask(dp_mask)
    );

    typedef struct {
        logic [31:0] dig;
        logic        err;
        logic [7:0]  dp;
    } frame_t;

    typedef struct {
        logic [31:0] dig;
        int          dwell;
        int          bad;
        logic [6:0]  bseg;
        logic [7:0]  dp;
        logic        valid;
        logic [31:0] exp_dig;
        logic        err;
    } vec_t;

    frame_t exp_q[$];
    vec_t tv[5];
    int checks = 0;
    int errors = 0;
    int frames = 0;
    int f0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic expect_frame(input logic [31:0] dig, input logic err, input logic [7:0] dp);
        frame_t f;
        f.dig = dig;
        f.err = err;
        f.dp = DP ? dp : 8'h00;
        exp_q.push_back(f);
    endtask

    task automatic show(input logic [7:0] en, input logic [6:0] seg, input logic dp, input int n);
        led_en = en;
        {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg;
        led_dp = dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        show(8'hFF, 7'h7F, 1'b1, n);
    endtask

    task automatic scan(input logic [31:0] dig, input int dwell, input int bad, input logic [6:0] bseg,
                        input logic [7:0] dp, input int first, input int last);
        for (int k = first; k >= last; k--)
            show(~(8'h01 << k), (k == bad) ? bseg : enc(dig[4*k +: 4]), ~dp[k], dwell);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid === 1'b1) begin
            frames++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame got=%h want=none", digits);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                chk("frame_digits", digits, e.dig);
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("frame_dp", {24'd0, dp_mask}, {24'd0, e.dp});
            end
        end
    end

    initial begin
        tv[0] = '{32'h10201028, 3, -1, 7'h7F, 8'h00, 1'b0, 32'hFFFFFFFF, 1'b0};
        tv[1] = '{32'h10201028, 4, -1, 7'h7F, 8'h00, 1'b1, 32'h10201028, 1'b0};
        tv[2] = '{32'h10201028, 4, 3, 7'b1010101, 8'h00, 1'b1, 32'h1020E028, 1'b1};
        tv[3] = '{32'h98765432, 4, -1, 7'h7F, 8'h81, 1'b1, 32'h98765432, 1'b0};
        tv[4] = '{32'h3456789F, 5, -1, 7'h7F, 8'h00, 1'b1, 32'h3456789F, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_digits", digits, 32'hFFFFFFFF);
        chk("rst_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_dp", {24'd0, dp_mask}, 32'd0);
        rst = 1'b0;
        blank(6);

        for (int i = 0; i < 5; i++) begin
            f0 = frames;
            if (tv[i].valid) expect_frame(tv[i].exp_dig, tv[i].err, tv[i].dp);
            scan(tv[i].dig, tv[i].dwell, tv[i].bad, tv[i].bseg, tv[i].dp, 7, 0);
            blank(4);
            chk($sformatf("vec%0d_frames", i), frames - f0, {31'd0, tv[i].valid});
            chk($sformatf("vec%0d_digits", i), digits, tv[i].exp_dig);
        end

        f0 = frames;
        expect_frame(32'h10201028, 1'b1, 8'h00);
        scan(32'h10201028, 4, -1, 7'h7F, 8'h00, 7, 4);
        show(8'h00, 7'h7F, 1'b1, 6);
        scan(32'h10201028, 4, -1, 7'h7F, 8'h00, 3, 0);
        blank(4);
        expect_frame(32'h10201028, 1'b0, 8'h00);
        scan(32'h10201028, 4, -1, 7'h7F, 8'h00, 7, 0);
        blank(4);
        chk("multi_low_frames", frames - f0, 32'd2);

        f0 = frames;
        scan(32'h00001111, 4, 2, 7'b1010101, 8'hFF, 4, 0);
        blank(70);
        chk("timeout_no_frame", frames - f0, 32'd0);
        chk("timeout_digits_hold", digits, 32'h10201028);
        expect_frame(32'h98765432, 1'b0, 8'h00);
        scan(32'h98765432, 4, -1, 7'h7F, 8'h00, 7, 0);
        blank(4);
        chk("timeout_frames", frames - f0, 32'd1);

        f0 = frames;
        scan(32'h00001234, 4, -1, 7'h7F, 8'h00, 3, 0);
        blank(2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_digits", digits, 32'hFFFFFFFF);
        chk("midrst_valid", {31'd0, frame_valid}, 32'd0);
        chk("midrst_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_dp", {24'd0, dp_mask}, 32'd0);
        rst = 1'b0;
        blank(4);
        expect_frame(32'h10201028, 1'b0, 8'h01);
        scan(32'h10201028, 4, -1, 7'h7F, 8'h01, 7, 0);
        blank(4);
        chk("midrst_frames", frames - f0, 32'd1);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
